// File: rtl/lpc_pkg.sv
// Shared types and codes for the passive LPC cycle decoder.
// The FWH_ID state exists only when LPC_FWH_EN is defined.
package lpc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    CTDIR,
    SIZE,
    ADDR,
    WDATA,
    TAR1,
    TAR2,
    SYNC,
    RDATA
`ifdef LPC_FWH_EN
    ,
    FWH_ID
`endif
  } state_t;

  localparam logic [1:0] CT_IO  = 2'b00;
  localparam logic [1:0] CT_MEM = 2'b01;

  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_SWAIT = 4'b0101;
  localparam logic [3:0] SYNC_LWAIT = 4'b0110;
  localparam logic [3:0] SYNC_ERR   = 4'b1010;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_SYNC    = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT = 2'b10;

  localparam logic [3:0] START_LPC    = 4'b0000;
  localparam logic [3:0] START_FWH_RD = 4'b1101;
  localparam logic [3:0] START_FWH_WR = 4'b1110;

  localparam logic [3:0] CTDIR_FWH_RD = 4'b1100;
  localparam logic [3:0] CTDIR_FWH_WR = 4'b1110;

  localparam logic [3:0] MSIZE_1 = 4'b0000;
  localparam logic [3:0] MSIZE_2 = 4'b0001;
  localparam logic [3:0] MSIZE_4 = 4'b0010;

  // LPC memory size field to byte count; 0 flags an illegal code.
  function automatic logic [2:0] lpc_size(input logic [1:0] code);
    unique case (code)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b11:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // FWH MSIZE nibble to byte count; 0 flags an illegal code.
  function automatic logic [2:0] lpc_msize(input logic [3:0] code);
    unique case (code)
      MSIZE_1: return 3'd1;
      MSIZE_2: return 3'd2;
      MSIZE_4: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lpc_cycle_decoder_if.sv
// LPC bus sample inputs plus the decoded record stream.
// master drives the bus, slave is the decoder.
interface lpc_cycle_decoder_if #(
  parameter int MAX_DATA_BYTES = 4
);
  logic                          lpc_frame;
  logic [3:0]                    lpc_ad;
  logic [3:0]                    out_cyctype_dir;
  logic [31:0]                   out_addr;
  logic [8*MAX_DATA_BYTES-1:0]   out_data;
  logic [2:0]                    out_data_size;
  logic [1:0]                    out_status;
  logic                          out_clock_enable;

  modport master (
    output lpc_frame,
    output lpc_ad,
    input  out_cyctype_dir,
    input  out_addr,
    input  out_data,
    input  out_data_size,
    input  out_status,
    input  out_clock_enable
  );

  modport slave (
    input  lpc_frame,
    input  lpc_ad,
    output out_cyctype_dir,
    output out_addr,
    output out_data,
    output out_data_size,
    output out_status,
    output out_clock_enable
  );
endinterface

// File: rtl/lpc_sync_timer.sv
// Saturating wait-SYNC counter; expired flags the wait
// nibble that brings the count up to SYNC_TIMEOUT.
module lpc_sync_timer #(
  parameter int SYNC_TIMEOUT = 255
) (
  input  logic lpc_clock,
  input  logic lpc_reset,
  input  logic clear,
  input  logic incr,
  output logic expired
);
  localparam logic [15:0] LIMIT = 16'(SYNC_TIMEOUT);

  logic [15:0] count_q;

  // wait count, cleared on entry to SYNC, held at the limit
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (incr && count_q != LIMIT) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign expired = incr && (count_q >= LIMIT - 16'd1);

endmodule

// File: rtl/lpc_cycle_decoder.sv
// Passive LPC I/O and memory cycle decoder, one record per cycle.
// Define LPC_FWH_EN to also decode firmware-hub cycles.
module lpc_cycle_decoder
  import lpc_pkg::*;
#(
  parameter int MAX_DATA_BYTES = 4,
  parameter int SYNC_TIMEOUT   = 255
) (
  input logic                lpc_clock,
  input logic                lpc_reset,
  lpc_cycle_decoder_if.slave bus
);
  localparam int DW = 8 * MAX_DATA_BYTES;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    alen_q, alen_d;
  logic [3:0]    ctdir_q, ctdir_d;
  logic          wr_q, wr_d;
  logic          fwh_q, fwh_d;
  logic [2:0]    size_q, size_d;
  logic [31:0]   addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  logic          emit;
  logic          zero_data;
  logic [1:0]    stat_d;
  logic [2:0]    sz;
  logic [3:0]    dlast;
  logic          t_clear;
  logic          t_incr;
  logic          t_expired;

  logic [3:0]    rec_ct;
  logic [31:0]   rec_addr;
  logic [DW-1:0] rec_data;
  logic [2:0]    rec_size;
  logic [1:0]    rec_stat;
  logic          rec_ce;

  lpc_sync_timer #(
    .SYNC_TIMEOUT(SYNC_TIMEOUT)
  ) u_timer (
    .lpc_clock(lpc_clock),
    .lpc_reset(lpc_reset),
    .clear    (t_clear),
    .incr     (t_incr),
    .expired  (t_expired)
  );

  assign dlast = {size_q, 1'b0} - 4'd1;

  // each state names the nibble being sampled this clock
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alen_d    = alen_q;
    ctdir_d   = ctdir_q;
    wr_d      = wr_q;
    fwh_d     = fwh_q;
    size_d    = size_q;
    addr_d    = addr_q;
    data_d    = data_q;
    emit      = 1'b0;
    zero_data = 1'b0;
    stat_d    = STAT_OK;
    sz        = 3'd0;
    t_clear   = 1'b0;
    t_incr    = 1'b0;
    if (!bus.lpc_frame) begin
      cnt_d   = '0;
      addr_d  = '0;
      data_d  = '0;
      fwh_d   = 1'b0;
      state_d = START;
      if (bus.lpc_ad == START_LPC) begin
        state_d = CTDIR;
      end
`ifdef LPC_FWH_EN
      else if (bus.lpc_ad == START_FWH_RD ||
               bus.lpc_ad == START_FWH_WR) begin
        state_d = FWH_ID;
        fwh_d   = 1'b1;
        wr_d    = (bus.lpc_ad == START_FWH_WR);
        ctdir_d = (bus.lpc_ad == START_FWH_WR) ?
                  CTDIR_FWH_WR : CTDIR_FWH_RD;
      end
`endif
    end else begin
      unique case (state_q)
        IDLE: ;
        START: state_d = IDLE;
        CTDIR: begin
          ctdir_d = {bus.lpc_ad[3:1], 1'b0};
          wr_d    = bus.lpc_ad[1];
          unique case (bus.lpc_ad[3:2])
            CT_IO: begin
              size_d  = 3'd1;
              alen_d  = 4'd4;
              state_d = ADDR;
            end
            CT_MEM: begin
              alen_d  = 4'd8;
              state_d = SIZE;
            end
            default: state_d = IDLE;
          endcase
        end
`ifdef LPC_FWH_EN
        FWH_ID: begin
          alen_d  = 4'd7;
          cnt_d   = '0;
          state_d = ADDR;
        end
`endif
        SIZE: begin
          sz = fwh_q ? lpc_msize(bus.lpc_ad)
                     : lpc_size(bus.lpc_ad[1:0]);
          cnt_d = '0;
          if (sz == 3'd0 || int'(sz) > MAX_DATA_BYTES) begin
            state_d = IDLE;
          end else begin
            size_d = sz;
            if (!fwh_q) state_d = ADDR;
            else if (wr_q) state_d = WDATA;
            else state_d = TAR1;
          end
        end
        ADDR: begin
          addr_d = {addr_q[27:0], bus.lpc_ad};
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == alen_q - 4'd1) begin
            cnt_d = '0;
            if (fwh_q) state_d = SIZE;
            else if (wr_q) state_d = WDATA;
            else state_d = TAR1;
          end
        end
        WDATA, RDATA: begin
          for (int i = 0; i < 2 * MAX_DATA_BYTES; i++) begin
            if (cnt_q == 4'(i)) data_d[4*i +: 4] = bus.lpc_ad;
          end
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == dlast) begin
            cnt_d = '0;
            if (state_q == WDATA) begin
              state_d = TAR1;
            end else begin
              emit    = 1'b1;
              state_d = IDLE;
            end
          end
        end
        TAR1: state_d = TAR2;
        TAR2: begin
          t_clear = 1'b1;
          state_d = SYNC;
        end
        SYNC: begin
          unique case (bus.lpc_ad)
            SYNC_READY: begin
              cnt_d = '0;
              if (wr_q) begin
                emit    = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = RDATA;
              end
            end
            SYNC_SWAIT, SYNC_LWAIT: begin
              t_incr = 1'b1;
              if (t_expired) begin
                emit      = 1'b1;
                zero_data = 1'b1;
                stat_d    = STAT_TIMEOUT;
                state_d   = IDLE;
              end
            end
            SYNC_ERR: begin
              emit      = 1'b1;
              zero_data = 1'b1;
              stat_d    = STAT_SYNC;
              state_d   = IDLE;
            end
            default: state_d = IDLE;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // decode state and partial cycle fields
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      alen_q  <= '0;
      ctdir_q <= '0;
      wr_q    <= 1'b0;
      fwh_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alen_q  <= alen_d;
      ctdir_q <= ctdir_d;
      wr_q    <= wr_d;
      fwh_q   <= fwh_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // record registers, loaded with a one-clock strobe
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      rec_ce   <= 1'b0;
      rec_ct   <= '0;
      rec_addr <= '0;
      rec_data <= '0;
      rec_size <= '0;
      rec_stat <= '0;
    end else begin
      rec_ce <= emit;
      if (emit) begin
        rec_ct   <= ctdir_q;
        rec_addr <= addr_q;
        rec_data <= zero_data ? '0 : data_d;
        rec_size <= size_q;
        rec_stat <= stat_d;
      end
    end
  end

  assign bus.out_clock_enable = rec_ce;
  assign bus.out_cyctype_dir  = rec_ct;
  assign bus.out_addr         = rec_addr;
  assign bus.out_data         = rec_data;
  assign bus.out_data_size    = rec_size;
  assign bus.out_status       = rec_stat;

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// Directed bench for lpc_cycle_decoder.
// Runs with SYNC_TIMEOUT=8; FWH case follows LPC_FWH_EN.
module tb_lpc_cycle_decoder;

  logic lpc_clock = 1'b0;
  logic lpc_reset = 1'b0;
  int   checks    = 0;
  int   failures  = 0;
  int   recs      = 0;
  int   base      = 0;

  lpc_cycle_decoder_if #(.MAX_DATA_BYTES(4)) bus ();

  lpc_cycle_decoder #(
    .MAX_DATA_BYTES(4),
    .SYNC_TIMEOUT  (8)
  ) dut (
    .lpc_clock(lpc_clock),
    .lpc_reset(lpc_reset),
    .bus      (bus)
  );

  always #5 lpc_clock = ~lpc_clock;

  always @(posedge lpc_clock) begin
    if (bus.out_clock_enable) recs <= recs + 1;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nib(input logic f, input logic [3:0] a);
    @(negedge lpc_clock);
    bus.lpc_frame = f;
    bus.lpc_ad    = a;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nib(1'b1, 4'hf);
  endtask

  task automatic addr_n(input logic [31:0] a, input int n);
    for (int i = n - 1; i >= 0; i--) nib(1'b1, a[4*i +: 4]);
  endtask

  task automatic data_n(input logic [31:0] d, input int nb);
    for (int i = 0; i < 2 * nb; i++) nib(1'b1, d[4*i +: 4]);
  endtask

  task automatic tar();
    nib(1'b1, 4'hf);
    nib(1'b1, 4'hf);
  endtask

  task automatic chk_rec(input string tag,
                         input logic [3:0] ct,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [2:0] sz,
                         input logic [1:0] st);
    @(negedge lpc_clock);
    chk({tag, ".ce"}, 64'(bus.out_clock_enable), 64'd1);
    chk({tag, ".ct"}, 64'(bus.out_cyctype_dir), 64'(ct));
    chk({tag, ".addr"}, 64'(bus.out_addr), 64'(a));
    chk({tag, ".data"}, 64'(bus.out_data), 64'(d));
    chk({tag, ".size"}, 64'(bus.out_data_size), 64'(sz));
    chk({tag, ".stat"}, 64'(bus.out_status), 64'(st));
    bus.lpc_frame = 1'b1;
    bus.lpc_ad    = 4'hf;
    @(negedge lpc_clock);
    chk({tag, ".ce_off"}, 64'(bus.out_clock_enable), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ce"}, 64'(bus.out_clock_enable), 64'd0);
    chk({tag, ".ct"}, 64'(bus.out_cyctype_dir), 64'd0);
    chk({tag, ".addr"}, 64'(bus.out_addr), 64'd0);
    chk({tag, ".data"}, 64'(bus.out_data), 64'd0);
    chk({tag, ".size"}, 64'(bus.out_data_size), 64'd0);
    chk({tag, ".stat"}, 64'(bus.out_status), 64'd0);
  endtask

  initial begin
    bus.lpc_frame = 1'b1;
    bus.lpc_ad    = 4'hf;
    repeat (2) @(negedge lpc_clock);
    chk_zero("rst");
    lpc_reset = 1'b1;
    idle(2);

    // memory read, 4 bytes
    nib(1'b0, 4'h0);
    nib(1'b1, 4'b0100);
    nib(1'b1, 4'b0011);
    addr_n(32'h12345678, 8);
    tar();
    nib(1'b1, 4'h0);
    data_n(32'h9abcdef0, 4);
    chk_rec("mrd", 4'b0100, 32'h12345678, 32'h9abcdef0, 3'd4, 2'b00);

    // memory write cut by reset in the address phase
    nib(1'b0, 4'h0);
    nib(1'b1, 4'b0110);
    nib(1'b1, 4'b0000);
    addr_n(32'h0000, 4);
    @(negedge lpc_clock);
    lpc_reset = 1'b0;
    nib(1'b1, 4'h7);
    nib(1'b1, 4'hf);
    chk_zero("mrst");
    lpc_reset = 1'b1;
    nib(1'b1, 4'he);
    nib(1'b1, 4'h1);
    data_n(32'h5a, 1);
    tar();
    nib(1'b1, 4'h0);
    idle(3);
    chk("mrst.recs", 64'(recs), 64'd1);

    // I/O read with four short waits
    nib(1'b0, 4'h0);
    nib(1'b1, 4'b0000);
    addr_n(32'h7fe5, 4);
    tar();
    repeat (4) nib(1'b1, 4'b0101);
    nib(1'b1, 4'h0);
    data_n(32'h6c, 1);
    chk_rec("iord", 4'b0000, 32'h00007fe5, 32'h6c, 3'd1, 2'b00);
    idle(2);
    chk("iord.recs", 64'(recs), 64'd2);

    // I/O write hitting the 8-wait timeout
    nib(1'b0, 4'h0);
    nib(1'b1, 4'b0010);
    addr_n(32'h0012, 4);
    data_n(32'h43, 1);
    tar();
    repeat (7) nib(1'b1, 4'b0110);
    @(negedge lpc_clock);
    chk("to.early", 64'(bus.out_clock_enable), 64'd0);
    bus.lpc_ad = 4'b0110;
    chk_rec("to", 4'b0010, 32'h0012, 32'h0, 3'd1, 2'b10);
    idle(2);

    // abort on the third address nibble, then a full I/O write
    base = recs;
    nib(1'b0, 4'h0);
    nib(1'b1, 4'b0010);
    nib(1'b1, 4'h0);
    nib(1'b1, 4'h0);
    nib(1'b0, 4'h0);
    nib(1'b1, 4'b0010);
    addr_n(32'h0080, 4);
    data_n(32'h55, 1);
    tar();
    nib(1'b1, 4'h0);
    chk_rec("abort", 4'b0010, 32'h0080, 32'h55, 3'd1, 2'b00);
    idle(2);
    chk("abort.recs", 64'(recs), 64'(base + 1));

    // sync error on an I/O read
    nib(1'b0, 4'h0);
    nib(1'b1, 4'b0000);
    addr_n(32'h1234, 4);
    tar();
    nib(1'b1, 4'b1010);
    chk_rec("serr", 4'b0000, 32'h1234, 32'h0, 3'd1, 2'b01);

    // memory write, 2 bytes
    nib(1'b0, 4'h0);
    nib(1'b1, 4'b0110);
    nib(1'b1, 4'b0001);
    addr_n(32'h000f0000, 8);
    data_n(32'hbeef, 2);
    tar();
    nib(1'b1, 4'h0);
    chk_rec("mwr2", 4'b0110, 32'h000f0000, 32'h0000beef, 3'd2, 2'b00);

    // frame low together with the final sync, then illegal size 10
    base = recs;
    nib(1'b0, 4'h0);
    nib(1'b1, 4'b0010);
    addr_n(32'h0040, 4);
    data_n(32'h77, 1);
    tar();
    nib(1'b0, 4'h0);
    idle(2);
    nib(1'b0, 4'h0);
    nib(1'b1, 4'b0100);
    nib(1'b1, 4'b0010);
    addr_n(32'h00001000, 8);
    tar();
    nib(1'b1, 4'h0);
    data_n(32'h12, 1);
    idle(3);
    chk("race.recs", 64'(recs), 64'(base));

    // firmware-hub read
    base = recs;
    nib(1'b0, 4'b1101);
    nib(1'b1, 4'h0);
    addr_n(32'h0ffffff0, 7);
    nib(1'b1, 4'b0010);
    tar();
    nib(1'b1, 4'h0);
    data_n(32'h11223344, 4);
`ifdef LPC_FWH_EN
    chk_rec("fwh", 4'b1100, 32'h0ffffff0, 32'h11223344, 3'd4, 2'b00);
    idle(2);
    chk("fwh.recs", 64'(recs), 64'(base + 1));
`else
    idle(3);
    chk("fwh.none", 64'(recs), 64'(base));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
